dma_sched: RTL



---
 rtl/dma_sched.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/dma_sched.sv
// dma_sched: queues DMA descriptors and issues them one at a time to the reader/writer engines.
// Optional completion watchdog enabled by defining DMA_SCHED_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a queued descriptor; pops and loads transfer outputs
// LAUNCH | start pulse(s) issued to reader/writer
// WAIT   | collecting reader/writer done pulses
// CMPL   | completion presented until cmpl_ready
module dma_sched #(
    parameter int          INTERNAL_RADDR_WIDTH = 64,
    parameter int          INTERNAL_WADDR_WIDTH = 64,
    parameter int          BTT_WIDTH            = 32,
    parameter int          TAG_WIDTH            = 8,
    parameter int          DEPTH                = 4,
    parameter int unsigned TIMEOUT_CYCLES       = 65535
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            desc_valid,
    output logic                            desc_ready,
    input  logic [INTERNAL_RADDR_WIDTH-1:0] desc_raddr,
    input  logic [INTERNAL_WADDR_WIDTH-1:0] desc_waddr,
    input  logic [BTT_WIDTH-1:0]            desc_btt,
    input  logic                            desc_write_zero,
    input  logic [TAG_WIDTH-1:0]            desc_tag,
    output logic [INTERNAL_RADDR_WIDTH-1:0] read_start_addr,
    output logic [INTERNAL_WADDR_WIDTH-1:0] write_start_addr,
    output logic [BTT_WIDTH-1:0]            btt,
    output logic                            write_zero,
    output logic                            reader_start,
    output logic                            writer_start,
    input  logic                            reader_done,
    input  logic                            writer_done,
    output logic                            cmpl_valid,
    input  logic                            cmpl_ready,
    output logic [TAG_WIDTH-1:0]            cmpl_tag,
    output logic                            cmpl_err,
    output logic                            busy,
    output logic [$clog2(DEPTH):0]          queue_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0) begin : g_cfg_check
        $error("dma_sched: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES nonzero");
    end

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CMPL} state_t;

    state_t state, state_nxt;

    logic [INTERNAL_RADDR_WIDTH-1:0] q_raddr [DEPTH];
    logic [INTERNAL_WADDR_WIDTH-1:0] q_waddr [DEPTH];
    logic [BTT_WIDTH-1:0]            q_btt   [DEPTH];
    logic                            q_wz    [DEPTH];
    logic [TAG_WIDTH-1:0]            q_tag   [DEPTH];

    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 push, pop;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 rd_done, wr_done, rd_done_nxt, wr_done_nxt, both_done;
    logic                 timeout;

    // Ready is based on the registered count only, so a pop in the same cycle does not raise it.
    assign desc_ready  = (count < CW'(DEPTH));
    assign push        = desc_valid & desc_ready;
    assign pop         = (state == S_IDLE) && (count != '0);
    assign queue_count = count;
    assign cmpl_tag    = tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_raddr[wr_ptr] <= desc_raddr;
            q_waddr[wr_ptr] <= desc_waddr;
            q_btt[wr_ptr]   <= desc_btt;
            q_wz[wr_ptr]    <= desc_write_zero;
            q_tag[wr_ptr]   <= desc_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_start_addr  <= '0;
            write_start_addr <= '0;
            btt              <= '0;
            write_zero       <= 1'b0;
            tag_q            <= '0;
        end else if (pop) begin
            read_start_addr  <= q_raddr[rd_ptr];
            write_start_addr <= q_waddr[rd_ptr];
            btt              <= q_btt[rd_ptr];
            write_zero       <= q_wz[rd_ptr];
            tag_q            <= q_tag[rd_ptr];
        end
    end

    // Done pulses only count while in WAIT; the current cycle's pulses take effect immediately.
    assign rd_done_nxt = rd_done | reader_done;
    assign wr_done_nxt = wr_done | writer_done;
    assign both_done   = rd_done_nxt & wr_done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            rd_done <= 1'b0;
            wr_done <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                rd_done <= 1'b0;
                wr_done <= 1'b0;
            end else if (state == S_LAUNCH) begin
                rd_done <= write_zero;
            end else if (state == S_WAIT) begin
                rd_done <= rd_done_nxt;
                wr_done <= wr_done_nxt;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        reader_start = 1'b0;
        writer_start = 1'b0;
        cmpl_valid   = 1'b0;
        busy         = (state != S_IDLE);
        case (state)
            S_IDLE:   if (pop) state_nxt = S_LAUNCH;
            S_LAUNCH: begin
                writer_start = 1'b1;
                reader_start = ~write_zero;
                state_nxt    = S_WAIT;
            end
            S_WAIT:   if (both_done || timeout) state_nxt = S_CMPL;
            S_CMPL:   begin
                cmpl_valid = 1'b1;
                if (cmpl_ready) state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

`ifdef DMA_SCHED_TIMEOUT_EN
    logic [31:0] wdog;
    logic        err_q;

    // Counter is 0 in the first WAIT cycle, so the limit is hit in WAIT cycle TIMEOUT_CYCLES.
    assign timeout  = (wdog == 32'(TIMEOUT_CYCLES - 1)) && !both_done;
    assign cmpl_err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == S_LAUNCH)    wdog <= '0;
            else if (state == S_WAIT) wdog <= wdog + 32'd1;
            if (state == S_WAIT && timeout)         err_q <= 1'b1;
            else if (state == S_CMPL && cmpl_ready) err_q <= 1'b0;
        end
    end
`else
    assign timeout  = 1'b0;
    assign cmpl_err = 1'b0;
`endif

endmodule
